// File: rtl/onewire_rom_reader.sv
// 1-Wire master: reset/presence, ROM command, 64-bit ROM read LSB-first, retries on failure.
// Define ONEWIRE_CRC_EN to add the Dallas CRC-8 check (err_code 10) after the ROM read.
module onewire_rom_reader #(
    parameter int unsigned CLK_MHZ = 100,
    parameter int unsigned RETRIES = 3,
    parameter logic [7:0]  ROM_CMD = 8'h33
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic        dq_in,
    output logic        dq_oe,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic        present,
    output logic [63:0] result
);
    localparam int unsigned PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

    // Phase end points are "last microsecond index" values: N us elapsed when us_q==N-1 at a tick.
    localparam logic [9:0] T_RST   = 10'd479;
    localparam logic [9:0] T_SLOT  = 10'd69;
    localparam logic [9:0] T_PRES  = 10'd69;
    localparam logic [9:0] T_SHORT = 10'd5;
    localparam logic [9:0] T_LONG  = 10'd59;
    localparam logic [9:0] T_RXS   = 10'd14;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_NOPRES = 2'b01;
`ifdef ONEWIRE_CRC_EN
    localparam logic [1:0] ERR_CRC    = 2'b10;
`endif
    localparam logic [1:0] ERR_STUCK  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_WAIT, TX_SLOT, RX_SLOT, CHECK, RETRY, FINISH
    } state_t;

    state_t         state_q;
    logic [1:0]     sync_q;
    logic [PW-1:0]  pre_q, pre_d;
    logic [9:0]     us_q, us_d;
    logic [5:0]     bit_q;
    logic [7:0]     sr_q;
    logic [2:0]     att_q;
    logic [1:0]     code_q;
    logic [63:0]    shadow_q;
    logic           dq_oe_q, busy_q, done_q, error_q, present_q;
    logic [1:0]     err_q;
    logic [63:0]    result_q;
    logic           dq_s, tick;
`ifdef ONEWIRE_CRC_EN
    logic [7:0]     crc_q, crc_d;
`endif

    assign dq_s = sync_q[1];

    always_comb begin
        tick = (pre_q == PW'(CLK_MHZ - 1));
        pre_d = tick ? '0 : pre_q + 1'b1;
        us_d  = tick ? us_q + 10'd1 : us_q;
    end

`ifdef ONEWIRE_CRC_EN
    always_comb begin
        crc_d = {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ dq_s) ? 8'h8C : 8'h00);
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sync_q    <= 2'b00;
            pre_q     <= '0;
            us_q      <= '0;
            bit_q     <= '0;
            sr_q      <= '0;
            att_q     <= '0;
            code_q    <= ERR_OK;
            shadow_q  <= '0;
            dq_oe_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_q     <= ERR_OK;
            present_q <= 1'b0;
            result_q  <= '0;
`ifdef ONEWIRE_CRC_EN
            crc_q     <= '0;
`endif
        end else begin
            sync_q <= {sync_q[0], dq_in};
            pre_q  <= pre_d;
            us_q   <= us_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (go) begin
                    busy_q    <= 1'b1;
                    error_q   <= 1'b0;
                    err_q     <= ERR_OK;
                    present_q <= 1'b0;
                    att_q     <= 3'(RETRIES);
                    if (!dq_s) begin
                        code_q  <= ERR_STUCK;
                        state_q <= FINISH;
                    end else begin
                        code_q  <= ERR_OK;
                        dq_oe_q <= 1'b1;
                        pre_q   <= '0;
                        us_q    <= '0;
                        state_q <= RST_LOW;
                    end
                end
                RST_LOW: if (tick && us_q == T_RST) begin
                    dq_oe_q <= 1'b0;
                    pre_q   <= '0;
                    us_q    <= '0;
                    state_q <= RST_WAIT;
                end
                RST_WAIT: if (tick) begin
                    if (us_q == T_PRES) present_q <= !dq_s;
                    if (us_q == T_RST) begin
                        pre_q <= '0;
                        us_q  <= '0;
                        if (present_q) begin
                            sr_q    <= ROM_CMD;
                            bit_q   <= '0;
                            dq_oe_q <= 1'b1;
                            state_q <= TX_SLOT;
                        end else begin
                            code_q  <= ERR_NOPRES;
                            state_q <= RETRY;
                        end
                    end
                end
                TX_SLOT: if (tick) begin
                    if (us_q == (sr_q[0] ? T_SHORT : T_LONG)) dq_oe_q <= 1'b0;
                    if (us_q == T_SLOT) begin
                        pre_q   <= '0;
                        us_q    <= '0;
                        dq_oe_q <= 1'b1;
                        sr_q    <= {1'b0, sr_q[7:1]};
                        bit_q   <= bit_q + 6'd1;
                        if (bit_q == 6'd7) begin
                            bit_q   <= '0;
                            state_q <= RX_SLOT;
`ifdef ONEWIRE_CRC_EN
                            crc_q   <= '0;
`endif
                        end
                    end
                end
                RX_SLOT: if (tick) begin
                    if (us_q == T_SHORT) dq_oe_q <= 1'b0;
                    if (us_q == T_RXS) begin
                        shadow_q[bit_q] <= dq_s;
`ifdef ONEWIRE_CRC_EN
                        crc_q <= crc_d;
`endif
                    end
                    if (us_q == T_SLOT) begin
                        pre_q <= '0;
                        us_q  <= '0;
                        if (bit_q == 6'd63) begin
`ifdef ONEWIRE_CRC_EN
                            state_q <= CHECK;
`else
                            code_q  <= ERR_OK;
                            state_q <= FINISH;
`endif
                        end else begin
                            dq_oe_q <= 1'b1;
                            bit_q   <= bit_q + 6'd1;
                        end
                    end
                end
`ifdef ONEWIRE_CRC_EN
                CHECK: begin
                    if (crc_q == 8'h00) begin
                        code_q  <= ERR_OK;
                        state_q <= FINISH;
                    end else begin
                        code_q  <= ERR_CRC;
                        state_q <= RETRY;
                    end
                end
`endif
                RETRY: begin
                    // code_q keeps the failure reason of the last attempt
                    if (att_q != 3'd0) begin
                        att_q   <= att_q - 3'd1;
                        dq_oe_q <= 1'b1;
                        pre_q   <= '0;
                        us_q    <= '0;
                        state_q <= RST_LOW;
                    end else begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    error_q <= (code_q != ERR_OK);
                    err_q   <= code_q;
                    if (code_q == ERR_OK) result_q <= shadow_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dq_oe    = dq_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_q;
    assign present  = present_q;
    assign result   = result_q;
endmodule

// File: doc/onewire_rom_reader.md
Name: onewire_rom_reader

Overview:
- Parametrised 1-Wire master; successor to the fixed DS2411 reader.
- Issues reset/presence, sends Read ROM (0x33), then reads the 64-bit ROM code LSB-first.
- Checks the Dallas CRC-8 and retries on failure; timing is derived from a clock-frequency parameter.
- Sits between a board-level open-drain DQ pad (external pull-up) and the slow-control register file, which reads result/status.

Parameters:
- CLK_MHZ, 100, clk cycles per microsecond (integer, >=4); all slot timing scales from this.
- RETRIES, 3, extra attempts after a failed attempt (0..7); total attempts = RETRIES+1.
- ROM_CMD, 8'h33, ROM command byte sent after presence, LSB-first.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- go  in  1  start request; sampled high in IDLE starts a transaction.
- dq_in  in  1  DQ pad level (asynchronous).
- dq_oe  out  1  1 = drive DQ low; 0 = release (pull-up).
- busy  out  1  high from the cycle after go is accepted until done.
- done  out  1  one-cycle pulse at transaction end (success or error).
- error  out  1  valid with done; held until next accepted go.
- err_code  out  2  00 ok, 01 no presence, 10 CRC mismatch, 11 bus stuck low.
- present  out  1  presence seen in the last reset slot.
- result  out  64  ROM code, bit 0 = first bit received (family code in [7:0]).

Behaviour:
- Reset (async assert, sync release): dq_oe=0, busy=0, done=0, error=0, err_code=00, present=0, result=0, all counters 0, state IDLE.
- Reset asserted mid-transaction releases DQ immediately, with no partial result.
- dq_in passes through a 2-flop synchroniser; all samples below use the synchronised value.
- Microsecond tick: a prescaler counts 0..CLK_MHZ-1; a 10-bit us counter times each phase.
- States and transitions:
  - IDLE: on go, if sync dq_in==0 -> FINISH with err 11 (no retry). Else -> RST_LOW; load attempt counter.
  - RST_LOW: dq_oe=1 for 480 us -> RST_WAIT.
  - RST_WAIT: release; sample at 70 us; present = !dq. At 480 us: if present, load ROM_CMD -> TX_SLOT; else -> RETRY with 01.
  - TX_SLOT: 70 us slot. Bit 1: low 6 us then release. Bit 0: low 60 us then release. Eight bits LSB-first -> RX_SLOT.
  - RX_SLOT: low 6 us, release, sample at 15 us from slot start, slot length 70 us. Shift into a shadow register at bit index 0..63; after bit 63 -> CHECK.
  - CHECK: CRC-8 (x^8+x^5+x^4+1, init 0, LSB-first) over all 64 bits must equal 0. Pass -> FINISH ok. Fail -> RETRY with 10.
  - RETRY: if attempts remain, decrement and -> RST_LOW; else -> FINISH with the stored code.
  - FINISH: done=1 for one cycle; error=(code!=00); result loaded from shadow only on ok (otherwise previous result kept); -> IDLE.
- busy stays high across retries.
- go while busy is ignored. go held high in IDLE starts a new transaction the cycle after done.
- Transaction duration on success, first attempt: 960 us + 72×70 us = 6000 us (600000 cycles at 100 MHz, ±4 cycles).
- Between slots DQ is released for at least 1 us (the slot includes recovery).

Optional Feature:
- Macro: ONEWIRE_CRC_EN.
- Defined: CHECK state present as described; err_code 10 possible.
- Undefined: CHECK omitted; after bit 63 go directly to FINISH ok; err_code 10 is never produced; retries occur only for missing presence.

Test Plan:
- Slave model with ROM 64'hA200000001B81C02, pulse go -> done after 6000±1 us; error=0; err_code=00; present=1; result=64'hA200000001B81C02.
- Same ROM with CRC byte corrupted to 8'hA3, RETRIES=3 -> 4 reset pulses; done with error=1, err_code=10; result unchanged from the prior value.
- No slave attached -> 4 reset pulses each 480 us low; done with err_code=01; present=0.
- DQ forced low before go -> done within 5 cycles; err_code=11; dq_oe never asserted.
- reset_n pulsed low at bit 20 of RX -> dq_oe=0 within the same cycle; all outputs at reset values; next go completes normally.
- Measure the ROM_CMD waveform: low pulses 6,6,60,60,6,6,60,60 us (0x33 LSB-first); go pulsed again while busy has no effect.
